// File: rtl/output_packer_pkg.sv
// Shared types for the output word packer.
// State encoding, lane type and word geometry.
package output_packer_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE,
    PACK,
    WRITE,
    DONE
  } packer_state_t;

endpackage

// File: rtl/byte_lane_packer.sv
// Four-lane byte register: lane-select write, zero-pad mask, clear.
// Lane 0 is the most significant byte of the packed word.
module byte_lane_packer
  import output_packer_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr_i,
  input  logic                           wr_i,
  input  logic [1:0]                     sel_i,
  input  byte_t                          din_i,
  input  logic [BYTES_PER_WORD-1:0]      pad_i,
  output byte_t [0:BYTES_PER_WORD-1]     lanes_o
);

  byte_t [0:BYTES_PER_WORD-1] lanes_q;

  // Write and pad masks never overlap, so per-lane priority is moot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes_q <= '0;
    end else if (clr_i) begin
      lanes_q <= '0;
    end else begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        if (wr_i && (sel_i == 2'(i)))
          lanes_q[i] <= din_i;
        else if (pad_i[i])
          lanes_q[i] <= '0;
      end
    end
  end

  assign lanes_o = lanes_q;

endmodule

// File: rtl/output_word_packer.sv
// Packs a byte stream into 32-bit words and issues one memory write
// per word with an incrementing byte address; flags done at job end.
module output_word_packer
  import output_packer_pkg::*;
#(
  parameter  int CAPACITY  = 128,
  parameter  int NUM_WORDS = 25,
  localparam int ADDR_W    = $clog2(CAPACITY),
  localparam int WCNT_W    = $clog2(NUM_WORDS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        flush,
  input  logic                        in_valid,
  input  byte_t                       in_byte,
  output logic                        in_ready,
  output logic                        write_en,
  output logic [ADDR_W-1:0]           addr,
  output byte_t [0:BYTES_PER_WORD-1]  out_bytes,
  output logic                        done
);

  packer_state_t       state_q;
  logic [1:0]          byte_cnt_q;
  logic [WCNT_W-1:0]   word_cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                in_ready_q;
  logic                write_en_q;
  logic                done_q;
  logic                flush_q;

  logic                accept;
  logic                flush_pack;
  logic [2:0]          fill;
  logic                go_write;
  logic [WCNT_W-1:0]   word_inc_d;
  logic [BYTES_PER_WORD-1:0] pad_mask;

  assign accept     = in_valid && in_ready_q;
  assign flush_pack = flush && !start && (state_q == PACK);
  assign fill       = {1'b0, byte_cnt_q} + {2'b00, accept};
  assign go_write   = (fill == 3'd4) || (flush && (fill != 3'd0));
  assign word_inc_d = word_cnt_q + 1'b1;

  // Lanes past the last filled byte are zeroed on a partial flush.
  always_comb begin
    pad_mask = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++)
      pad_mask[i] = flush_pack && (fill != 3'd0) && (3'(i) >= fill);
  end

  byte_lane_packer u_lanes (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (start),
    .wr_i    (accept && !start),
    .sel_i   (byte_cnt_q),
    .din_i   (in_byte),
    .pad_i   (pad_mask),
    .lanes_o (out_bytes)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
      in_ready_q <= 1'b0;
      write_en_q <= 1'b0;
      done_q     <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      write_en_q <= 1'b0;
      if (start) begin
        state_q    <= PACK;
        byte_cnt_q <= '0;
        word_cnt_q <= '0;
        in_ready_q <= 1'b1;
        done_q     <= 1'b0;
        flush_q    <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: ;
          PACK: begin
            if (accept)
              byte_cnt_q <= byte_cnt_q + 2'd1;
            if (go_write) begin
              state_q    <= WRITE;
              byte_cnt_q <= '0;
              write_en_q <= 1'b1;
              in_ready_q <= 1'b0;
              addr_q     <= ADDR_W'({word_cnt_q, 2'b00});
              flush_q    <= flush;
            end else if (flush) begin
              state_q    <= DONE;
              in_ready_q <= 1'b0;
              done_q     <= 1'b1;
            end
          end
          WRITE: begin
            word_cnt_q <= word_inc_d;
            flush_q    <= 1'b0;
            if (flush_q || (word_inc_d == WCNT_W'(NUM_WORDS))) begin
              state_q    <= DONE;
              done_q     <= 1'b1;
            end else begin
              state_q    <= PACK;
              in_ready_q <= 1'b1;
            end
          end
          DONE: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign in_ready = in_ready_q;
  assign write_en = write_en_q;
  assign addr     = addr_q;
  assign done     = done_q;

endmodule
